// File: rtl/cacheline_adaptor_if.sv
// Cache-side and memory-side signal bundle for cacheline_adaptor.
// The adaptor uses the slave modport; the driving environment uses master.
interface cacheline_adaptor_if #(
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned BURST_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH  = 32
);

  // Cache side
  logic                   read_i;
  logic                   write_i;
  logic [ADDR_WIDTH-1:0]  address_i;
  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic                   resp_o;

  // Memory side
  logic [ADDR_WIDTH-1:0]  address_o;
  logic                   read_o;
  logic                   write_o;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [BURST_WIDTH-1:0] burst_i;
  logic                   resp_i;

  modport slave (
    input  read_i, write_i, address_i, line_i, burst_i, resp_i,
    output line_o, resp_o, address_o, read_o, write_o, burst_o
  );

  modport master (
    output read_i, write_i, address_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, read_o, write_o, burst_o
  );

endinterface

// File: rtl/cacheline_adaptor.sv
// Memory-side endpoint for the L1 line arrays: assembles fill bursts into a line
// and splits a writeback line into a burst. One transaction in flight at a time.
module cacheline_adaptor #(
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned BURST_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  cacheline_adaptor_if.slave bus
);

  localparam int unsigned BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int unsigned OFS   = $clog2(LINE_WIDTH / 8);
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LastBeat = CW'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e                            state_q, state_d;
  logic [CW-1:0]                     count_q, count_d;
  logic [BEATS-1:0][BURST_WIDTH-1:0] line_q;
  logic [BEATS-1:0][BURST_WIDTH-1:0] wbuf_q;
  logic [ADDR_WIDTH-1:0]             addr_q;

  logic accept;
  logic capture;
  logic read_out;
  logic write_out;
  logic resp_out;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    accept    = 1'b0;
    capture   = 1'b0;
    read_out  = 1'b0;
    write_out = 1'b0;
    resp_out  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Writeback wins so a dirty victim leaves before its replacement arrives.
        if (bus.write_i) begin
          accept  = 1'b1;
          count_d = '0;
          state_d = StWr;
        end else if (bus.read_i) begin
          accept  = 1'b1;
          count_d = '0;
          state_d = StRd;
        end
      end
      StRd: begin
        read_out = 1'b1;
        if (bus.resp_i) begin
          capture = 1'b1;
          if (count_q == LastBeat) begin
            count_d = '0;
            state_d = StDone;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      StWr: begin
        write_out = 1'b1;
        if (bus.resp_i) begin
          if (count_q == LastBeat) begin
            count_d = '0;
            state_d = StDone;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      StDone: begin
        resp_out = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
      wbuf_q <= '0;
      addr_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= {bus.address_i[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
        wbuf_q <= bus.line_i;
      end
      if (capture) begin
        line_q[count_q] <= bus.burst_i;
      end
    end
  end

  assign bus.line_o    = line_q;
  assign bus.address_o = addr_q;
  assign bus.burst_o   = wbuf_q[count_q];
  assign bus.read_o    = read_out;
  assign bus.write_o   = write_out;
  assign bus.resp_o    = resp_out;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: fills, writebacks, beat gaps, request
// priority, mid-burst reset and stray memory strobes.
module tb_cacheline_adaptor;

  localparam int unsigned LW = 256;
  localparam int unsigned BW = 64;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_adaptor_if #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

  cacheline_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int resp_cnt = 0;
  int resp_base;
  int k;

  logic [BW-1:0] fa [4];
  logic [BW-1:0] fb [4];
  logic [BW-1:0] fd [4];
  logic [BW-1:0] fe [4];
  logic [LW-1:0] line_a, line_b, line_d, line_e;
  logic [LW-1:0] wl, wm, wn;
  logic [6:0]    pat;
  logic          flag_a, flag_b;

  always @(negedge clk) if (bus.resp_o) resp_cnt++;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.address_i = '0;
    bus.line_i    = '0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;

    for (int i = 0; i < 4; i++) begin
      fa[i] = 64'hA0A0_0000_0000_0000 + 64'(i);
      fb[i] = 64'hB0B0_0000_0000_0000 + 64'(i);
      fd[i] = 64'hD0D0_0000_0000_0000 + 64'(i);
      fe[i] = 64'hE0E0_0000_0000_0000 + 64'(i);
    end
    line_a = {fa[3], fa[2], fa[1], fa[0]};
    line_b = {fb[3], fb[2], fb[1], fb[0]};
    line_d = {fd[3], fd[2], fd[1], fd[0]};
    line_e = {fe[3], fe[2], fe[1], fe[0]};
    wl = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    wm = {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
          64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001};
    wn = ~wl;

    // Reset state
    repeat (2) tick();
    check("rst_line_o",    bus.line_o, '0);
    check("rst_address_o", LW'(bus.address_o), '0);
    check("rst_burst_o",   LW'(bus.burst_o), '0);
    check("rst_resp_o",    LW'(bus.resp_o), '0);
    check("rst_read_o",    LW'(bus.read_o), '0);
    check("rst_write_o",   LW'(bus.write_o), '0);
    rst = 1'b0;
    tick();

    // 1: back-to-back fill at 0x1234
    bus.address_i = 32'h0000_1234;
    bus.read_i    = 1'b1;
    tick();
    check("t1_address_o", LW'(bus.address_o), LW'(32'h0000_1220));
    check("t1_read_o",    LW'(bus.read_o), LW'(1'b1));
    bus.address_i = 32'hFFFF_FFFF;
    flag_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      flag_a |= bus.resp_o;
      bus.resp_i  = 1'b1;
      bus.burst_i = fa[i];
      tick();
    end
    bus.resp_i = 1'b0;
    check("t1_no_early_resp", LW'(flag_a), '0);
    check("t1_resp_o",        LW'(bus.resp_o), LW'(1'b1));
    check("t1_read_o_done",   LW'(bus.read_o), '0);
    check("t1_line_o",        bus.line_o, line_a);
    check("t1_address_held",  LW'(bus.address_o), LW'(32'h0000_1220));
    tick();
    bus.read_i = 1'b0;
    check("t1_resp_one_cycle", LW'(bus.resp_o), '0);
    check("t1_line_held",      bus.line_o, line_a);

    // 2: writeback of wl at 0x8000_00E0, line_i changed after accept
    bus.address_i = 32'h8000_00E0;
    bus.line_i    = wl;
    bus.write_i   = 1'b1;
    tick();
    check("t2_write_o",   LW'(bus.write_o), LW'(1'b1));
    check("t2_address_o", LW'(bus.address_o), LW'(32'h8000_00E0));
    bus.line_i = wn;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_burst%0d", i), LW'(bus.burst_o), LW'(wl[i*BW +: BW]));
      bus.resp_i = 1'b1;
      tick();
    end
    bus.resp_i = 1'b0;
    check("t2_resp_o",     LW'(bus.resp_o), LW'(1'b1));
    check("t2_write_done", LW'(bus.write_o), '0);
    check("t2_line_kept",  bus.line_o, line_a);
    tick();
    bus.write_i = 1'b0;
    check("t2_resp_low", LW'(bus.resp_o), '0);

    // 3: fill with resp_i gap pattern 1,0,0,1,1,0,1
    pat           = 7'b1011001;
    bus.address_i = 32'h0000_4000;
    bus.read_i    = 1'b1;
    tick();
    k      = 0;
    flag_a = 1'b0;
    flag_b = 1'b0;
    for (int s = 0; s < 7; s++) begin
      if (!bus.read_o) flag_a = 1'b1;
      if (bus.resp_o) flag_b = 1'b1;
      bus.resp_i  = pat[s];
      bus.burst_i = pat[s] ? fb[k] : 64'hDEAD_BEEF_DEAD_BEEF;
      if (pat[s]) k++;
      tick();
    end
    bus.resp_i = 1'b0;
    check("t3_read_o_held",   LW'(flag_a), '0);
    check("t3_no_early_resp", LW'(flag_b), '0);
    check("t3_resp_o",        LW'(bus.resp_o), LW'(1'b1));
    check("t3_line_o",        bus.line_o, line_b);
    tick();
    bus.read_i = 1'b0;

    // 4: read and write together -> writeback first
    bus.address_i = 32'h0000_2040;
    bus.line_i    = wm;
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b1;
    tick();
    check("t4_write_o", LW'(bus.write_o), LW'(1'b1));
    check("t4_read_o",  LW'(bus.read_o), '0);
    for (int i = 0; i < 4; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
      tick();
    end
    bus.resp_i = 1'b0;
    check("t4_resp_o",    LW'(bus.resp_o), LW'(1'b1));
    check("t4_no_fill",   bus.line_o, line_b);
    tick();
    bus.write_i = 1'b0;
    check("t4_idle_no_read", LW'(bus.read_o), '0);
    tick();
    check("t4_read_resampled", LW'(bus.read_o), LW'(1'b1));

    // 5: reset after two beats of the fill just started
    for (int i = 0; i < 2; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = 64'hC0C0_0000_0000_0000 + 64'(i);
      tick();
    end
    bus.resp_i = 1'b0;
    rst        = 1'b1;
    #1;
    check("t5_rst_read_o",    LW'(bus.read_o), '0);
    check("t5_rst_line_o",    bus.line_o, '0);
    check("t5_rst_address_o", LW'(bus.address_o), '0);
    check("t5_rst_resp_o",    LW'(bus.resp_o), '0);
    bus.read_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    bus.address_i = 32'h0000_3000;
    bus.read_i    = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = fd[i];
      tick();
    end
    bus.resp_i = 1'b0;
    check("t5_resp_o", LW'(bus.resp_o), LW'(1'b1));
    check("t5_line_o", bus.line_o, line_d);
    tick();
    bus.read_i = 1'b0;

    // 6: stray strobes in IDLE, then fill followed by writeback
    resp_base = resp_cnt;
    flag_a    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = 64'h5555_5555_5555_5555;
      tick();
      if (bus.read_o || bus.write_o || bus.resp_o) flag_a = 1'b1;
    end
    bus.resp_i = 1'b0;
    check("t6_stray_outputs", LW'(flag_a), '0);
    check("t6_stray_line",    bus.line_o, line_d);
    bus.address_i = 32'h0000_5000;
    bus.read_i    = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = fe[i];
      tick();
    end
    bus.resp_i    = 1'b0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b1;
    bus.line_i    = wn;
    bus.address_i = 32'h0000_6000;
    tick();
    tick();
    check("t6_write_o", LW'(bus.write_o), LW'(1'b1));
    flag_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = 64'h7777_7777_7777_7777;
      tick();
      if (bus.line_o !== line_e) flag_b = 1'b1;
    end
    bus.resp_i = 1'b0;
    check("t6_line_stable", LW'(flag_b), '0);
    tick();
    bus.write_i = 1'b0;
    repeat (3) tick();
    check("t6_resp_count", LW'(resp_cnt - resp_base), LW'(2));
    check("t6_line_final", bus.line_o, line_e);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
